// File: rtl/par_ser_tx.sv
// -----------------------------------------------------------------------------
// par_ser_tx
//   Parallel-in / serial-out transmitter. A Depth-bit word is accepted on a
//   valid/ready handshake and shifted out MSB-first on D_out, each bit held for
//   BIT_CYCLES clocks. An optional even-parity bit and an idle gap of
//   GAP_CYCLES clocks follow the word. bit_strobe marks the last clock of each
//   data/parity bit so a downstream shift register can use it as its enable.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous reset, active-high
//   data_in    in   word to send, sampled only on accept
//   valid_in   in   data_in valid
//   ready_out  out  high only in IDLE (decoded from state)
//   D_out      out  serial data, registered
//   bit_strobe out  high on the last clock of each data/parity bit, registered
//   busy       out  high from the cycle after accept until back in IDLE
//   done       out  one-cycle pulse in the first clock after the final bit
// -----------------------------------------------------------------------------
module par_ser_tx #(
    parameter int Depth      = 4,
    parameter int BIT_CYCLES = 1,
    parameter int PARITY_EN  = 1,
    parameter int GAP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [Depth-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             D_out,
    output logic             bit_strobe,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int IDX_W = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(Depth - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        GAP    = 2'd3
    } state_t;

    // Where the FSM goes once the last data/parity bit has been sent.
    localparam state_t AFTER_FRAME = (GAP_CYCLES > 0) ? GAP : IDLE;

    // Control state
    state_t           state,   state_n;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_n;
    logic [IDX_W-1:0] bit_idx, bit_idx_n;
    logic [GAP_W-1:0] gap_cnt, gap_cnt_n;
    logic             frame_end;

    // Datapath state (not reset: only observed while a frame is in flight)
    logic [Depth-1:0] shreg, shreg_n;
    logic             par,   par_n;

    // Next values of the registered outputs
    logic d_out_n;
    logic strobe_n;
    logic busy_n;
    logic done_n;

    assign ready_out = (state == IDLE);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            gap_cnt    <= '0;
            D_out      <= 1'b0;
            bit_strobe <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            bit_idx    <= bit_idx_n;
            gap_cnt    <= gap_cnt_n;
            D_out      <= d_out_n;
            bit_strobe <= strobe_n;
            busy       <= busy_n;
            done       <= done_n;
        end
    end

    always_ff @(posedge clk) begin
        shreg <= shreg_n;
        par   <= par_n;
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        bit_idx_n = bit_idx;
        gap_cnt_n = gap_cnt;
        shreg_n   = shreg;
        par_n     = par;
        frame_end = 1'b0;

        case (state)
            IDLE: begin
                if (valid_in) begin
                    state_n   = DATA;
                    shreg_n   = data_in;
                    par_n     = ^data_in;
                    bit_cnt_n = '0;
                    bit_idx_n = '0;
                end
            end

            DATA: begin
                if (bit_cnt == CNT_LAST) begin
                    bit_cnt_n = '0;
                    shreg_n   = shreg << 1;
                    if (bit_idx == IDX_LAST) begin
                        bit_idx_n = '0;
                        gap_cnt_n = '0;
                        if (PARITY_EN != 0) begin
                            state_n = PARITY;
                        end else begin
                            state_n   = AFTER_FRAME;
                            frame_end = 1'b1;
                        end
                    end else begin
                        bit_idx_n = bit_idx + IDX_W'(1);
                    end
                end else begin
                    bit_cnt_n = bit_cnt + CNT_W'(1);
                end
            end

            PARITY: begin
                if (bit_cnt == CNT_LAST) begin
                    bit_cnt_n = '0;
                    gap_cnt_n = '0;
                    state_n   = AFTER_FRAME;
                    frame_end = 1'b1;
                end else begin
                    bit_cnt_n = bit_cnt + CNT_W'(1);
                end
            end

            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_n = IDLE;
                end else begin
                    gap_cnt_n = gap_cnt + GAP_W'(1);
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic
    //   Outputs are registered, so they are decoded from the *next* state and
    //   counters; that way the first bit appears in the cycle right after accept.
    // -------------------------------------------------------------------------
    always_comb begin
        d_out_n  = 1'b0;
        strobe_n = 1'b0;
        busy_n   = (state_n != IDLE);
        done_n   = frame_end;

        case (state_n)
            DATA: begin
                d_out_n  = shreg_n[Depth-1];
                strobe_n = (bit_cnt_n == CNT_LAST);
            end
            PARITY: begin
                d_out_n  = par_n;
                strobe_n = (bit_cnt_n == CNT_LAST);
            end
            default: begin
                d_out_n  = 1'b0;
                strobe_n = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_par_ser_tx.sv
// -----------------------------------------------------------------------------
// tb_par_ser_tx
//   Three instances of par_ser_tx:
//     u_a : Depth=4, BIT_CYCLES=1, PARITY_EN=1, GAP_CYCLES=1
//     u_b : Depth=4, BIT_CYCLES=3, PARITY_EN=0, GAP_CYCLES=1
//     u_c : Depth=4, BIT_CYCLES=1, PARITY_EN=1, GAP_CYCLES=0
//   Expected serial bits are queued when a word is offered and popped on every
//   bit_strobe; cycle-exact checks of strobe/done/ready/busy are done inline.
// -----------------------------------------------------------------------------
module tb_par_ser_tx;

    logic clk;

    logic       rst_a, valid_a, ready_a, dout_a, strobe_a, busy_a, done_a;
    logic [3:0] data_a;
    logic       rst_b, valid_b, ready_b, dout_b, strobe_b, busy_b, done_b;
    logic [3:0] data_b;
    logic       rst_c, valid_c, ready_c, dout_c, strobe_c, busy_c, done_c;
    logic [3:0] data_c;

    int n_tests;
    int n_fail;

    logic q_a[$];
    logic q_b[$];
    logic q_c[$];

    logic [3:0] sr_a;

    par_ser_tx #(.Depth(4), .BIT_CYCLES(1), .PARITY_EN(1), .GAP_CYCLES(1)) u_a (
        .clk(clk), .rst(rst_a), .data_in(data_a), .valid_in(valid_a),
        .ready_out(ready_a), .D_out(dout_a), .bit_strobe(strobe_a),
        .busy(busy_a), .done(done_a)
    );

    par_ser_tx #(.Depth(4), .BIT_CYCLES(3), .PARITY_EN(0), .GAP_CYCLES(1)) u_b (
        .clk(clk), .rst(rst_b), .data_in(data_b), .valid_in(valid_b),
        .ready_out(ready_b), .D_out(dout_b), .bit_strobe(strobe_b),
        .busy(busy_b), .done(done_b)
    );

    par_ser_tx #(.Depth(4), .BIT_CYCLES(1), .PARITY_EN(1), .GAP_CYCLES(0)) u_c (
        .clk(clk), .rst(rst_c), .data_in(data_c), .valid_in(valid_c),
        .ready_out(ready_c), .D_out(dout_c), .bit_strobe(strobe_c),
        .busy(busy_c), .done(done_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_a(input logic [3:0] w);
        for (int i = 3; i >= 0; i--) q_a.push_back(w[i]);
        q_a.push_back(^w);
    endtask

    task automatic push_b(input logic [3:0] w);
        for (int i = 3; i >= 0; i--) q_b.push_back(w[i]);
    endtask

    task automatic push_c(input logic [3:0] w);
        for (int i = 3; i >= 0; i--) q_c.push_back(w[i]);
        q_c.push_back(^w);
    endtask

    // Downstream ser_reg model: shifts D_out in on bit_strobe.
    always @(posedge clk) begin
        if (strobe_a === 1'b1) sr_a <= {sr_a[2:0], dout_a};
    end

    // Scoreboard: every strobed bit must match the next queued bit.
    always @(negedge clk) begin
        logic e;
        if (strobe_a === 1'b1) begin
            e = (q_a.size() > 0) ? q_a.pop_front() : 1'bx;
            chk("a_sb_bit", dout_a, e);
        end
        if (strobe_b === 1'b1) begin
            e = (q_b.size() > 0) ? q_b.pop_front() : 1'bx;
            chk("b_sb_bit", dout_b, e);
        end
        if (strobe_c === 1'b1) begin
            e = (q_c.size() > 0) ? q_c.pop_front() : 1'bx;
            chk("c_sb_bit", dout_c, e);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] w;
        logic       exp_d;
        n_tests = 0;
        n_fail  = 0;
        sr_a    = 4'h0;

        // ---- Reset with valid_in held high: nothing may be accepted ----
        rst_a = 1'b1; valid_a = 1'b1; data_a = 4'hF;
        rst_b = 1'b1; valid_b = 1'b0; data_b = 4'h0;
        rst_c = 1'b1; valid_c = 1'b0; data_c = 4'h0;
        tick();
        tick();
        chk("rst_a_dout",   dout_a,   0);
        chk("rst_a_busy",   busy_a,   0);
        chk("rst_a_ready",  ready_a,  1);
        chk("rst_a_strobe", strobe_a, 0);
        chk("rst_a_done",   done_a,   0);
        chk("rst_b_ready",  ready_b,  1);
        chk("rst_c_ready",  ready_c,  1);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        valid_a = 1'b0;
        tick();
        chk("post_rst_a_busy", busy_a, 0);

        // ---- Single frame 4'b1011 on u_a ----
        w = 4'b1011;
        data_a = w; valid_a = 1'b1; push_a(w);
        tick();
        valid_a = 1'b0; data_a = 4'h0;
        for (int c = 1; c <= 7; c++) begin
            exp_d = (c <= 4) ? w[4 - c] : ((c == 5) ? ^w : 1'b0);
            chk($sformatf("t2_dout_c%0d", c),   dout_a,   exp_d);
            chk($sformatf("t2_strobe_c%0d", c), strobe_a, (c <= 5));
            chk($sformatf("t2_done_c%0d", c),   done_a,   (c == 6));
            chk($sformatf("t2_ready_c%0d", c),  ready_a,  (c >= 7));
            chk($sformatf("t2_busy_c%0d", c),   busy_a,   (c <= 6));
            if (c == 5) chk("t2_ser_reg", sr_a, 4'b1011);
            if (c < 7) tick();
        end

        // ---- valid_in held with a new word during the frame ----
        data_a = 4'b1100; valid_a = 1'b1; push_a(4'b1100);
        tick();
        data_a = 4'b1001; push_a(4'b1001);
        for (int c = 1; c <= 7; c++) begin
            chk($sformatf("t4_ready_c%0d", c), ready_a, (c == 7));
            chk($sformatf("t4_busy_c%0d", c),  busy_a,  (c <= 6));
            if (c < 7) tick();
        end
        tick();
        valid_a = 1'b0; data_a = 4'b1111;
        chk("t4_second_busy",   busy_a,   1);
        chk("t4_second_strobe", strobe_a, 1);
        chk("t4_second_dout",   dout_a,   1);
        for (int i = 0; i < 20 && ready_a !== 1'b1; i++) tick();
        chk("t4_idle_reached", ready_a, 1);
        chk("t4_queue_empty", q_a.size(), 0);

        // ---- Reset in cycle 3 of a frame ----
        data_a = 4'b0110; valid_a = 1'b1; push_a(4'b0110);
        tick();
        valid_a = 1'b0; data_a = 4'h0;
        tick();
        tick();
        rst_a = 1'b1;
        tick();
        chk("t5_dout",   dout_a,   0);
        chk("t5_strobe", strobe_a, 0);
        chk("t5_busy",   busy_a,   0);
        chk("t5_done",   done_a,   0);
        chk("t5_ready",  ready_a,  1);
        q_a.delete();
        rst_a = 1'b0;
        for (int c = 5; c <= 7; c++) begin
            tick();
            chk($sformatf("t5_no_done_c%0d", c), done_a, 0);
        end
        data_a = 4'b1010; valid_a = 1'b1; push_a(4'b1010);
        tick();
        valid_a = 1'b0; data_a = 4'h0;
        chk("t5_new_first_dout", dout_a, 1);
        for (int i = 0; i < 20 && ready_a !== 1'b1; i++) tick();
        chk("t5_idle_reached", ready_a, 1);
        chk("t5_queue_empty", q_a.size(), 0);

        // ---- BIT_CYCLES=3, no parity, word 4'b0110 on u_b ----
        w = 4'b0110;
        data_b = w; valid_b = 1'b1; push_b(w);
        tick();
        valid_b = 1'b0; data_b = 4'h0;
        for (int c = 1; c <= 14; c++) begin
            exp_d = (c <= 12) ? w[3 - (c - 1) / 3] : 1'b0;
            chk($sformatf("t3_dout_c%0d", c),   dout_b,   exp_d);
            chk($sformatf("t3_strobe_c%0d", c), strobe_b, (c <= 12) && (c % 3 == 0));
            chk($sformatf("t3_done_c%0d", c),   done_b,   (c == 13));
            chk($sformatf("t3_ready_c%0d", c),  ready_b,  (c >= 14));
            if (c < 14) tick();
        end
        chk("t3_queue_empty", q_b.size(), 0);

        // ---- GAP_CYCLES=0, word 4'b0000, back-to-back accept on u_c ----
        data_c = 4'b0000; valid_c = 1'b1; push_c(4'b0000);
        tick();
        data_c = 4'b1101; push_c(4'b1101);
        for (int c = 1; c <= 6; c++) begin
            chk($sformatf("t6_dout_c%0d", c),   dout_c,   0);
            chk($sformatf("t6_strobe_c%0d", c), strobe_c, (c <= 5));
            chk($sformatf("t6_done_c%0d", c),   done_c,   (c == 6));
            chk($sformatf("t6_ready_c%0d", c),  ready_c,  (c == 6));
            chk($sformatf("t6_busy_c%0d", c),   busy_c,   (c <= 5));
            if (c < 6) tick();
        end
        tick();
        valid_c = 1'b0; data_c = 4'h0;
        chk("t6_b2b_busy",   busy_c,   1);
        chk("t6_b2b_strobe", strobe_c, 1);
        chk("t6_b2b_dout",   dout_c,   1);
        chk("t6_b2b_done",   done_c,   0);
        for (int i = 0; i < 20 && ready_c !== 1'b1; i++) tick();
        chk("t6_idle_reached", ready_c, 1);
        chk("t6_queue_empty", q_c.size(), 0);

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
